fw_boot_loader: RTL and testbench

Synthesizable firmware loader sitting directly upstream of the 6502 memory and CPU. It accepts a firmware byte stream over a valid/ready handshake and writes it into memory starting at a fixed load base. It then writes the reset vector (0xFFFC/0xFFFD) to point at that base and releases the CPU from reset. It replaces the bench-only memory-override path for loading programs, so the same boot sequence runs in simulation and on hardware.

---
 rtl/fw_boot_loader.sv | 103 ++++++++++
 tb/tb_fw_boot_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fw_boot_loader.sv
// fw_boot_loader: streams a firmware image into memory at LOAD_BASE, points the 6502
// reset vector at it, then releases the CPU from reset.
module fw_boot_loader #(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    REG_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = 16'h8000,
    parameter int                    MAX_SIZE   = 4096,
    parameter logic [ADDR_WIDTH-1:0] VEC_ADDR   = 16'hFFFC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [REG_WIDTH-1:0]  byte_data,
    input  logic                  byte_last,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_din,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] load_count
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VEC_LO, S_VEC_HI, S_DONE, S_ERROR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LP_LAST_IDX = ADDR_WIDTH'(MAX_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] LP_ONE      = ADDR_WIDTH'(1);

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_count, w_count;
    logic [ADDR_WIDTH-1:0] r_mem_addr, w_addr;
    logic [REG_WIDTH-1:0]  r_mem_din, w_din;
    logic                  r_mem_we, w_we;
    logic                  r_released;
    logic                  w_accept;

    assign byte_ready = r_state == S_LOAD;
    assign w_accept   = byte_valid & byte_ready;

    always_comb begin
        w_next  = r_state;
        w_count = r_count;
        w_we    = 1'b0;
        w_addr  = r_mem_addr;
        w_din   = r_mem_din;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: if (start) begin
                w_next  = S_LOAD;
                w_count = '0;
            end
            S_LOAD: if (w_accept) begin
                w_we    = 1'b1;
                w_addr  = LOAD_BASE + r_count;
                w_din   = byte_data;
                w_count = r_count + LP_ONE;
                w_next  = byte_last ? S_VEC_LO : (r_count == LP_LAST_IDX ? S_ERROR : S_LOAD);
            end
            S_VEC_LO: begin
                w_we   = 1'b1;
                w_addr = VEC_ADDR;
                w_din  = REG_WIDTH'(LOAD_BASE[7:0]);
                w_next = S_VEC_HI;
            end
            S_VEC_HI: begin
                w_we   = 1'b1;
                w_addr = VEC_ADDR + LP_ONE;
                w_din  = REG_WIDTH'(LOAD_BASE[15:8]);
                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Release waits one extra cycle in DONE so the high vector byte is captured first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_released <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_count    <= w_count;
            r_mem_we   <= w_we;
            r_mem_addr <= w_addr;
            r_mem_din  <= w_din;
            r_released <= (r_state == S_DONE) && (w_next == S_DONE);
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_din     = r_mem_din;
    assign load_count  = r_count;
    assign cpu_reset_n = r_released;
    assign done        = r_released;
    assign busy        = (r_state == S_LOAD) || (r_state == S_VEC_LO) || (r_state == S_VEC_HI);
    assign error       = r_state == S_ERROR;
endmodule

// File: tb/tb_fw_boot_loader.sv
// tb_fw_boot_loader: directed and randomized loads checked against an image-level model.
module tb_fw_boot_loader;
    localparam int MAXS = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic        clk, reset_n, start, byte_valid, byte_last;
    logic [7:0]  byte_data;
    logic        byte_ready, mem_we, cpu_reset_n, busy, done, error;
    logic [15:0] mem_addr, load_count;
    logic [7:0]  mem_din;

    int   checks = 0;
    int   failures = 0;
    wr_t  wlog[$];
    logic [7:0] tbmem [0:65535];

    fw_boot_loader #(.MAX_SIZE(MAXS)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error),
        .load_count(load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) begin
        wlog.push_back('{a: mem_addr, d: mem_din});
        tbmem[mem_addr] <= mem_din;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, byte_ready, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_din"}, mem_din, 0);
        chk({tag, "_cpu_rst_n"}, cpu_reset_n, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_count"}, load_count, 0);
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge following the final posedge used.
    task automatic stream(input logic [7:0] q[$], input bit has_last, input int lead,
                          input int gap_pct, input int start_cyc, output int acc, output int cyc);
        acc = 0;
        cyc = 0;
        while (acc < q.size() && cyc < 200) begin
            if (!byte_ready) break;
            start = (cyc == start_cyc);
            if (cyc < lead || int'($urandom_range(99)) < gap_pct) begin
                byte_valid = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = q[acc];
                byte_last  = has_last && (acc == q.size() - 1);
            end
            @(posedge clk);
            if (byte_valid) acc++;
            cyc++;
            @(negedge clk);
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        start      = 1'b0;
        chk("stream_within_budget", cyc < 200, 1);
    endtask

    // Image-level model: an image completes only if its last byte falls within MAXS bytes.
    task automatic expect_load(input string tag, input logic [7:0] q[$], input bit has_last,
                               input int base, input int acc);
        int  n  = q.size();
        bit  ok = has_last && n <= MAXS;
        int  nb = ok ? n : MAXS;
        chk({tag, "_accepted"}, acc, nb);
        chk({tag, "_writes"}, wlog.size() - base, nb + (ok ? 2 : 0));
        for (int i = 0; i < nb; i++) if (base + i < wlog.size()) begin
            chk({tag, "_img_addr"}, wlog[base+i].a, 32'h8000 + i);
            chk({tag, "_img_data"}, wlog[base+i].d, q[i]);
        end
        if (ok && base + nb + 1 < wlog.size()) begin
            chk({tag, "_veclo"}, {wlog[base+nb].a, wlog[base+nb].d}, {16'hFFFC, 8'h00});
            chk({tag, "_vechi"}, {wlog[base+nb+1].a, wlog[base+nb+1].d}, {16'hFFFD, 8'h80});
        end
        chk({tag, "_done"}, done, ok);
        chk({tag, "_cpu_rst_n"}, cpu_reset_n, ok);
        chk({tag, "_error"}, error, !ok);
        chk({tag, "_count"}, load_count, nb);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] q[$];
        int acc, cyc, base;
        bit has_last;
        reset_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", byte_ready, 0);

        // Three-byte back-to-back load with cycle-accurate vector/release timing
        pulse_start;
        chk("t1_ready", byte_ready, 1);
        chk("t1_busy", busy, 1);
        q = '{8'hA9, 8'h01, 8'h00};
        base = wlog.size();
        stream(q, 1, 0, 0, -1, acc, cyc);
        chk("t1_cycles", cyc, 3);
        chk("t1_last_we", {mem_we, mem_addr, mem_din}, {1'b1, 16'h8002, 8'h00});
        @(negedge clk);
        chk("t1_veclo_bus", {mem_we, mem_addr, mem_din}, {1'b1, 16'hFFFC, 8'h00});
        @(negedge clk);
        chk("t1_vechi_bus", {mem_we, mem_addr, mem_din}, {1'b1, 16'hFFFD, 8'h80});
        chk("t1_cpu_held", cpu_reset_n, 0);
        @(negedge clk);
        chk("t1_cpu_released", cpu_reset_n, 1);
        chk("t1_we_low_hold", {mem_we, mem_addr}, {1'b0, 16'hFFFD});
        repeat (2) @(negedge clk);
        expect_load("t1", q, 1, base, acc);
        chk("t1_mem8000", tbmem[16'h8000], 8'hA9);

        // Gapped single-byte image
        pulse_start;
        q = '{8'hEA};
        base = wlog.size();
        stream(q, 1, 4, 0, -1, acc, cyc);
        chk("t2_cycles", cyc, 5);
        repeat (4) @(negedge clk);
        expect_load("t2", q, 1, base, acc);

        // Overflow: five bytes, no last
        pulse_start;
        chk("t3_done_cleared", done, 0);
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        base = wlog.size();
        stream(q, 0, 0, 0, -1, acc, cyc);
        repeat (4) @(negedge clk);
        expect_load("t3", q, 0, base, acc);
        chk("t3_ready_low", byte_ready, 0);

        // Error recovery
        pulse_start;
        chk("t6_error_cleared", error, 0);
        chk("t6_count_cleared", load_count, 0);
        q = '{8'hD8, 8'h58};
        base = wlog.size();
        stream(q, 1, 0, 0, -1, acc, cyc);
        repeat (4) @(negedge clk);
        expect_load("t6", q, 1, base, acc);

        // start pulsed mid-load is ignored
        pulse_start;
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        base = wlog.size();
        stream(q, 1, 0, 0, 2, acc, cyc);
        repeat (4) @(negedge clk);
        expect_load("t4a", q, 1, base, acc);

        // Restart from DONE
        pulse_start;
        chk("t4b_cpu_low", cpu_reset_n, 0);
        q = '{8'h60};
        base = wlog.size();
        stream(q, 1, 0, 0, -1, acc, cyc);
        repeat (4) @(negedge clk);
        expect_load("t4b", q, 1, base, acc);

        // Asynchronous reset mid-load
        pulse_start;
        q = '{8'h5A, 8'hC3};
        stream(q, 0, 0, 0, -1, acc, cyc);
        chk("t5_accepted", acc, 2);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk_reset_outputs("t5_async");
        chk("t5_mem8000", tbmem[16'h8000], 8'h5A);
        chk("t5_mem8001", tbmem[16'h8001], 8'hC3);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_idle_ready", byte_ready, 0);
        chk("t5_idle_busy", busy, 0);

        // Randomized images
        for (int it = 0; it < 20; it++) begin
            int n = int'($urandom_range(1, 6));
            has_last = (n < MAXS) ? 1'b1 : 1'($urandom_range(1));
            q = {};
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            pulse_start;
            base = wlog.size();
            stream(q, has_last, int'($urandom_range(0, 2)), 30, -1, acc, cyc);
            repeat (5) @(negedge clk);
            expect_load("rnd", q, has_last, base, acc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
